// File: rtl/dmx1to4_router.sv
// Buffered 1-to-4 demultiplexer. A single valid/ready input stream is steered by
// in_sel into one of four independent FIFOs, and each FIFO drains through its own port.
module dmx1to4_router #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic             idle
);

    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW       = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [CW-1:0]    count_q  [4];
    logic [CW-1:0]    count_d  [4];
    logic [PW-1:0]    wr_ptr_q [4];
    logic [PW-1:0]    wr_ptr_d [4];
    logic [PW-1:0]    rd_ptr_q [4];
    logic [PW-1:0]    rd_ptr_d [4];
    logic [WIDTH-1:0] mem_q    [4][DEPTH];
    logic [WIDTH-1:0] head     [4];
    logic [3:0]       full;
    logic [3:0]       push;
    logic [3:0]       pop;

    // NOTE: every variable gets a default at the top so no path can infer a latch.
    always_comb begin
        full      = '0;
        out_valid = '0;
        push      = '0;
        pop       = '0;
        for (int n = 0; n < 4; n++) begin
            full[n]      = (count_q[n] == FULL_CNT);
            out_valid[n] = (count_q[n] != '0);
        end

        // A full channel refuses even when it pops this cycle: no slot pass-through.
        in_ready = en && !full[in_sel];
        idle     = ~|out_valid;

        for (int n = 0; n < 4; n++) begin
            push[n]     = in_valid && in_ready && (in_sel == 2'(n));
            pop[n]      = out_valid[n] && out_ready[n];
            count_d[n]  = count_q[n];
            wr_ptr_d[n] = wr_ptr_q[n];
            rd_ptr_d[n] = rd_ptr_q[n];
            if (push[n] && !pop[n]) begin
                count_d[n] = count_q[n] + CW'(1);
            end else if (pop[n] && !push[n]) begin
                count_d[n] = count_q[n] - CW'(1);
            end
            if (push[n]) wr_ptr_d[n] = wr_ptr_q[n] + PW'(1);
            if (pop[n])  rd_ptr_d[n] = rd_ptr_q[n] + PW'(1);
            head[n] = out_valid[n] ? mem_q[n][rd_ptr_q[n]] : '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) begin
                count_q[n]  <= '0;
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                count_q[n]  <= count_d[n];
                wr_ptr_q[n] <= wr_ptr_d[n];
                rd_ptr_q[n] <= rd_ptr_d[n];
            end
        end
    end

    // NOTE: storage is not reset; out_valid gating keeps stale entries from ever reaching outputs.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (push[n]) mem_q[n][wr_ptr_q[n]] <= in_data;
        end
    end

    assign out_data0 = head[0];
    assign out_data1 = head[1];
    assign out_data2 = head[2];
    assign out_data3 = head[3];

endmodule

// File: tb/tb_dmx1to4_router.sv
// Directed bench for dmx1to4_router: a per-channel scoreboard queue is filled when a
// push is expected to be accepted and drained/compared when the consumer pops.
module tb_dmx1to4_router;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
    logic             idle;
    logic [WIDTH-1:0] od [4];

    int n_checks = 0;
    int n_pass   = 0;

    logic [WIDTH-1:0] sb [4][$];

    dmx1to4_router #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Outputs sampled in the middle of a cycle, compared with the scoreboard state.
    task automatic check_outputs(input string tag, input logic e, input logic [1:0] sel);
        logic [3:0]       ev;
        logic [WIDTH-1:0] ed;
        ev = '0;
        for (int n = 0; n < 4; n++) ev[n] = (sb[n].size() != 0);
        check({tag, ".in_ready"}, in_ready, e && (sb[sel].size() < DEPTH));
        check({tag, ".out_valid"}, out_valid, ev);
        check({tag, ".idle"}, idle, ev == 4'b0000);
        for (int n = 0; n < 4; n++) begin
            ed = '0;
            if (ev[n]) ed = sb[n][0];
            check($sformatf("%s.out_data%0d", tag, n), od[n], ed);
        end
    endtask

    // Called at posedge+1: drive, check at posedge+2, update the model, advance one edge.
    task automatic cycle(input logic v, input logic [1:0] sel, input logic [WIDTH-1:0] d,
                         input logic [3:0] ordy, input logic e, input string tag);
        logic       exp_rdy;
        logic [3:0] pop_m;
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = ordy;
        en        = e;
        #1;
        check_outputs(tag, e, sel);
        exp_rdy = e && (sb[sel].size() < DEPTH);
        for (int n = 0; n < 4; n++) pop_m[n] = ordy[n] && (sb[n].size() != 0);
        for (int n = 0; n < 4; n++) if (pop_m[n]) void'(sb[n].pop_front());
        if (v && exp_rdy) sb[sel].push_back(d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = 2'd0;
        out_ready = 4'b0000;

        #2;
        check("reset.in_ready_en1", in_ready, 1'b1);
        check("reset.out_valid", out_valid, 4'b0000);
        check("reset.idle", idle, 1'b1);
        check("reset.out_data0", out_data0, 4'h0);
        en = 1'b0;
        #1;
        check("reset.in_ready_en0", in_ready, 1'b0);
        en = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single beat to ch2, visible next cycle, then popped.
        cycle(1'b1, 2'd2, 4'hA, 4'b0000, 1'b1, "basic.push");
        cycle(1'b0, 2'd2, 4'h0, 4'b0100, 1'b1, "basic.pop");
        cycle(1'b0, 2'd0, 4'h0, 4'b0000, 1'b1, "basic.idle");

        // Fill ch1, its stall must not block ch3, then drain in order.
        cycle(1'b1, 2'd1, 4'h1, 4'b0000, 1'b1, "ch1.push1");
        cycle(1'b1, 2'd1, 4'h2, 4'b0000, 1'b1, "ch1.push2");
        cycle(1'b1, 2'd1, 4'h9, 4'b0000, 1'b1, "ch1.full");
        cycle(1'b1, 2'd3, 4'h7, 4'b0000, 1'b1, "ch3.bypass");
        cycle(1'b0, 2'd1, 4'h0, 4'b0010, 1'b1, "ch1.pop1");
        cycle(1'b0, 2'd1, 4'h0, 4'b0010, 1'b1, "ch1.pop2");
        cycle(1'b0, 2'd3, 4'h0, 4'b1000, 1'b1, "ch3.pop");

        // Full ch0 popping in the same cycle still refuses the word.
        cycle(1'b1, 2'd0, 4'h3, 4'b0000, 1'b1, "ch0.fill1");
        cycle(1'b1, 2'd0, 4'h4, 4'b0000, 1'b1, "ch0.fill2");
        cycle(1'b1, 2'd0, 4'h5, 4'b0001, 1'b1, "ch0.full_pop");
        cycle(1'b1, 2'd0, 4'h5, 4'b0000, 1'b1, "ch0.accept");
        cycle(1'b1, 2'd0, 4'h6, 4'b0000, 1'b1, "ch0.full_again");
        cycle(1'b0, 2'd0, 4'h0, 4'b0001, 1'b1, "ch0.drain1");
        cycle(1'b0, 2'd0, 4'h0, 4'b0001, 1'b1, "ch0.drain2");

        // Ch3 with one word: simultaneous push/pop keeps count, pointers wrap.
        cycle(1'b1, 2'd3, 4'hB, 4'b0000, 1'b1, "ch3.one");
        cycle(1'b1, 2'd3, 4'hC, 4'b1000, 1'b1, "ch3.pushpop");
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            cycle(1'b1, 2'd3, 4'(i + 1), 4'b1000, 1'b1, $sformatf("ch3.wrap%0d", i));
        end
        cycle(1'b0, 2'd3, 4'h0, 4'b1000, 1'b1, "ch3.drain");

        // en low blocks acceptance on every channel while buffered words drain.
        cycle(1'b1, 2'd1, 4'hD, 4'b0000, 1'b1, "en.preload");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 2'(i), 4'hE, (i >= 3) ? 4'b0010 : 4'b0000, 1'b0, $sformatf("en.off%0d", i));
        end

        // Asynchronous reset in mid-cycle discards buffered words at once.
        cycle(1'b1, 2'd0, 4'h9, 4'b0000, 1'b1, "rst.fill0");
        cycle(1'b1, 2'd2, 4'h6, 4'b0000, 1'b1, "rst.fill2");
        cycle(1'b1, 2'd0, 4'h8, 4'b0000, 1'b1, "rst.fill0b");
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        en        = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.mid.out_valid", out_valid, 4'b0000);
        check("rst.mid.idle", idle, 1'b1);
        check("rst.mid.in_ready", in_ready, 1'b1);
        check("rst.mid.data", {out_data0, out_data1, out_data2, out_data3}, 16'h0000);
        for (int n = 0; n < 4; n++) sb[n].delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 2'd0, 4'h5, 4'b0000, 1'b1, "rst.fresh_push");
        cycle(1'b0, 2'd0, 4'h0, 4'b0001, 1'b1, "rst.fresh_pop");

        // Mixed random traffic against the scoreboard.
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0), $sformatf("rand%0d", i));
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 2'd0, 4'h0, 4'b1111, 1'b1, $sformatf("final.drain%0d", i));
        end
        cycle(1'b0, 2'd0, 4'h0, 4'b0000, 1'b1, "final.idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
